// File: rtl/button_conditioner.sv
// Multi-channel pushbutton front end: synchronise, debounce, then emit one-cycle
// press/release events plus an optional hold-to-repeat pulse train per channel.
module button_conditioner #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic [N_CH-1:0] event_pulse
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HELD
  } state_e;

  // Polarity is normalised before the first sync flop so everything downstream is "1 = pressed".
  logic [N_CH-1:0] pressed_raw;
  assign pressed_raw = raw ^ {N_CH{ACTIVE_LOW}};

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = pressed_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // NOTE: the synchroniser chain is reset too, so a stale "pressed" sample
  // cannot leak out of reset; clearing it costs nothing on a short chain.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) sync_q[i] <= '0;
      else       sync_q[i] <= sync_d[i];
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic             synced;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             level_q, level_d;
    logic             press_q, release_q, repeat_q, repeat_d;
    logic             rise, fall;
    state_e           state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    assign synced = sync_q[SYNC_STAGES-1][ch];

    // Debounce: a differing level must persist DEBOUNCE_CYCLES edges in a row.
    always_comb begin
      // NOTE: every comb output gets a default first, so no path infers a latch.
      db_cnt_d = '0;
      level_d  = level_q;
      if (synced != level_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) level_d  = ~level_q;
        else                                        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Repeat FSM, next-state process.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        ST_IDLE:  if (rise) state_d = repeat_en[ch] ? ST_ARMED : ST_HELD;
        ST_ARMED: begin
          if (fall)               state_d = ST_IDLE;
          else if (!repeat_en[ch]) state_d = ST_HELD;
        end
        ST_HELD:  if (fall) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Repeat FSM, output process: release and enable drop both pre-empt an expiring repeat.
    always_comb begin
      rpt_cnt_d = '0;
      repeat_d  = 1'b0;
      unique case (state_q)
        ST_IDLE: if (rise && repeat_en[ch]) rpt_cnt_d = RPT_W'(REPEAT_DELAY);
        ST_ARMED: begin
          if (!fall && repeat_en[ch]) begin
            if (rpt_cnt_q == RPT_W'(1)) begin
              repeat_d  = 1'b1;
              rpt_cnt_d = RPT_W'(REPEAT_PERIOD);
            end else begin
              rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // State register for debounce, FSM and registered pulses.
    always_ff @(posedge clk) begin
      if (reset) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        state_q   <= ST_IDLE;
        rpt_cnt_q <= '0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= rise;
        release_q <= fall;
        repeat_q  <= repeat_d;
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign level[ch]         = level_q;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = release_q;
    assign repeat_pulse[ch]  = repeat_q;
    assign event_pulse[ch]   = press_q | repeat_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus, all
// compared each cycle against an edge-level behavioural model of both instances.
module tb_button_conditioner;

  localparam int N_CH = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DLY  = 8;
  localparam int PER  = 3;

  logic clk = 1'b0;
  logic reset;
  logic [N_CH-1:0] raw, repeat_en, raw_al, repeat_en_al;
  logic [N_CH-1:0] level, press_pulse, release_pulse, repeat_pulse, event_pulse;
  logic [N_CH-1:0] al_level, al_press, al_release, al_repeat, al_event;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .raw(raw), .repeat_en(repeat_en),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .event_pulse(event_pulse)
  );

  button_conditioner #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .reset(reset), .raw(raw_al), .repeat_en(repeat_en_al),
    .level(al_level), .press_pulse(al_press), .release_pulse(al_release),
    .repeat_pulse(al_repeat), .event_pulse(al_event)
  );

  // Model: channels 0..1 belong to dut, 2..3 to dut_al.
  bit dl [4][$];
  bit m_level [4];
  bit m_press [4];
  bit m_release [4];
  bit m_repeat [4];
  bit m_armed [4];
  int m_run [4];
  int m_press_edge [4];
  int m_edge = 0;

  task automatic model_step();
    bit p [4];
    bit en [4];
    bit synced, new_level;
    int k;
    p[0] = raw[0];      p[1] = raw[1];
    p[2] = ~raw_al[0];  p[3] = ~raw_al[1];
    en[0] = repeat_en[0];    en[1] = repeat_en[1];
    en[2] = repeat_en_al[0]; en[3] = repeat_en_al[1];
    m_edge++;
    for (int ch = 0; ch < 4; ch++) begin
      if (reset) begin
        dl[ch].delete();
        for (int i = 0; i < SYNC; i++) dl[ch].push_back(1'b0);
        m_level[ch] = 0; m_press[ch] = 0; m_release[ch] = 0;
        m_repeat[ch] = 0; m_armed[ch] = 0; m_run[ch] = 0;
      end else begin
        synced = dl[ch].pop_front();
        dl[ch].push_back(p[ch]);
        new_level = m_level[ch];
        if (synced != m_level[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            new_level = ~m_level[ch];
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
        m_press[ch]   = new_level & ~m_level[ch];
        m_release[ch] = ~new_level & m_level[ch];
        m_repeat[ch]  = 0;
        if (m_press[ch]) begin
          m_armed[ch] = en[ch];
          m_press_edge[ch] = m_edge;
        end else if (m_armed[ch]) begin
          k = m_edge - m_press_edge[ch];
          if (m_release[ch] || !en[ch]) m_armed[ch] = 0;
          else if (k >= DLY && (k - DLY) % PER == 0) m_repeat[ch] = 1;
        end
        m_level[ch] = new_level;
      end
    end
  endtask

  function automatic logic [9:0] exp_vec(int b);
    logic [1:0] l, p, r, q;
    l = {m_level[b+1], m_level[b]};
    p = {m_press[b+1], m_press[b]};
    r = {m_release[b+1], m_release[b]};
    q = {m_repeat[b+1], m_repeat[b]};
    return {l, p, r, q, p | q};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {level, press_pulse, release_pulse, repeat_pulse, event_pulse};
  endfunction

  function automatic logic [9:0] al_vec();
    return {al_level, al_press, al_release, al_repeat, al_event};
  endfunction

  // One clock: model sees the same inputs the DUT samples; outputs settle by #1.
  task automatic tick();
    @(posedge clk);
    model_step();
    if (reset) edge_no = 0;
    else       edge_no++;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw = 2'b11; repeat_en = 2'b11; raw_al = 2'b00; repeat_en_al = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({dut_vec(), al_vec()} !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %b want all zero", i, {dut_vec(), al_vec()});
      end
    end
    raw = 2'b00; repeat_en = 2'b00; raw_al = 2'b11; repeat_en_al = 2'b00;
    reset = 1'b0;
  endtask

  task automatic test_single_press();
    logic [7:0] want;
    raw = 2'b00; repeat_en = 2'b00;
    apply_reset();
    raw = 2'b01;
    for (int i = 0; i < 30; i++) begin
      tick();
      want = {1'b0, edge_no >= 6, 1'b0, edge_no == 6, 4'b0000};
      checks++;
      if ({level, press_pulse, repeat_pulse, release_pulse} !== want) begin
        errors++;
        $display("FAIL single_press edge %0d got %b want %b", edge_no,
                 {level, press_pulse, repeat_pulse, release_pulse}, want);
      end
      checks++;
      if (dut_vec() !== exp_vec(0)) begin
        errors++;
        $display("FAIL single_press_model edge %0d got %b want %b", edge_no, dut_vec(), exp_vec(0));
      end
    end
  endtask

  task automatic test_bounce();
    int n_press = 0;
    raw = 2'b00; repeat_en = 2'b00;
    apply_reset();
    for (int e = 1; e <= 25; e++) begin
      raw[0] = (e >= 2 && e != 5);
      tick();
      if (press_pulse[0]) n_press++;
      checks++;
      if (press_pulse[0] !== (edge_no == 11) || level[0] !== (edge_no >= 11)) begin
        errors++;
        $display("FAIL bounce edge %0d got press=%b level=%b want press=%b level=%b", edge_no,
                 press_pulse[0], level[0], edge_no == 11, edge_no >= 11);
      end
      checks++;
      if (dut_vec() !== exp_vec(0)) begin
        errors++;
        $display("FAIL bounce_model edge %0d got %b want %b", edge_no, dut_vec(), exp_vec(0));
      end
    end
    checks++;
    if (n_press !== 1) begin
      errors++;
      $display("FAIL bounce_press_count got %0d want 1", n_press);
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] got, want;
    bit rep;
    raw = 2'b00; repeat_en = 2'b01;
    apply_reset();
    for (int e = 1; e <= 36; e++) begin
      raw[0] = (e <= 20);
      raw[1] = 1'($urandom_range(0, 1));
      tick();
      rep  = (edge_no == 14 || edge_no == 17 || edge_no == 20 || edge_no == 23);
      got  = {press_pulse[0], repeat_pulse[0], event_pulse[0], release_pulse[0]};
      want = {edge_no == 6, rep, rep || edge_no == 6, edge_no == 26};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL auto_repeat edge %0d got %b want %b", edge_no, got, want);
      end
      checks++;
      if (dut_vec() !== exp_vec(0)) begin
        errors++;
        $display("FAIL auto_repeat_model edge %0d got %b want %b", edge_no, dut_vec(), exp_vec(0));
      end
    end
  endtask

  task automatic test_repeat_disable();
    logic [2:0] got, want;
    bit rep;
    raw = 2'b00; repeat_en = 2'b00;
    apply_reset();
    for (int e = 1; e <= 75; e++) begin
      repeat_en[0] = !(e >= 15 && e <= 17);
      raw[0] = (e <= 40) || (e >= 51);
      tick();
      rep  = (edge_no == 14) || (edge_no >= 64 && (edge_no - 64) % 3 == 0);
      got  = {press_pulse[0], repeat_pulse[0], release_pulse[0]};
      want = {edge_no == 6 || edge_no == 56, rep, edge_no == 46};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL repeat_disable edge %0d got %b want %b", edge_no, got, want);
      end
      checks++;
      if (dut_vec() !== exp_vec(0)) begin
        errors++;
        $display("FAIL repeat_disable_model edge %0d got %b want %b", edge_no, dut_vec(), exp_vec(0));
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] got, want;
    raw = 2'b00; repeat_en = 2'b00;
    apply_reset();
    raw = 2'b11; repeat_en = 2'b11;
    for (int k = 1; k <= 26; k++) begin
      reset = (k == 10);
      tick();
      got  = {level, press_pulse, release_pulse, repeat_pulse};
      want = {((k >= 6 && k < 10) || k >= 16) ? 2'b11 : 2'b00,
              (k == 6 || k == 16) ? 2'b11 : 2'b00, 2'b00,
              (k == 24) ? 2'b11 : 2'b00};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_hold k %0d got %b want %b", k, got, want);
      end
      checks++;
      if (dut_vec() !== exp_vec(0)) begin
        errors++;
        $display("FAIL reset_mid_hold_model k %0d got %b want %b", k, dut_vec(), exp_vec(0));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_active_low();
    logic [5:0] got, want;
    raw = 2'b00; repeat_en = 2'b00; raw_al = 2'b11; repeat_en_al = 2'b00;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (al_vec() !== 10'h0) begin
        errors++;
        $display("FAIL active_low_idle edge %0d got %b want all zero", edge_no, al_vec());
      end
    end
    apply_reset();
    for (int e = 1; e <= 25; e++) begin
      raw_al[0] = !(e <= 10);
      tick();
      got  = {al_level, al_press, al_release};
      want = {1'b0, edge_no >= 6 && edge_no < 16, 1'b0, edge_no == 6, 1'b0, edge_no == 16};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL active_low edge %0d got %b want %b", edge_no, got, want);
      end
      checks++;
      if (al_vec() !== exp_vec(2)) begin
        errors++;
        $display("FAIL active_low_model edge %0d got %b want %b", edge_no, al_vec(), exp_vec(2));
      end
    end
  endtask

  task automatic test_random();
    int hold [4];
    for (int ch = 0; ch < 4; ch++) hold[ch] = 0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          if (ch < 2) raw[ch] = ~raw[ch];
          else        raw_al[ch-2] = ~raw_al[ch-2];
          hold[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
        end else begin
          hold[ch]--;
        end
      end
      if ($urandom_range(0, 29) == 0) repeat_en    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) repeat_en_al = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 599) == 0);
      tick();
      checks++;
      if ({dut_vec(), al_vec()} !== {exp_vec(0), exp_vec(2)}) begin
        errors++;
        $display("FAIL random cycle %0d got %b want %b", i, {dut_vec(), al_vec()},
                 {exp_vec(0), exp_vec(2)});
      end
      checks++;
      if ((press_pulse & repeat_pulse) !== 2'b00 || (press_pulse & release_pulse) !== 2'b00 ||
          (release_pulse & repeat_pulse) !== 2'b00) begin
        errors++;
        $display("FAIL random_exclusive cycle %0d got p=%b r=%b q=%b want disjoint", i,
                 press_pulse, release_pulse, repeat_pulse);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_disable();
    test_reset_mid_hold();
    test_active_low();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
